// File: rtl/pipeline_drain.sv
// Consumer end of the ena-advanced two-stage pipeline: only advances the pipeline
// when a FIFO slot is guaranteed, buffers shifted-out words, and re-presents them on valid/ready.
module pipeline_drain #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv_req,
  input  logic [SIZE-1:0]          up_data,
  input  logic                     up_valid,
  output logic                     ena,
  output logic [SIZE-1:0]          dn_data,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         rcvd_cnt,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            push;
  logic            pop;
  logic            space;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a word.
  assign pop      = dn_valid & dn_ready;
  assign space    = (level < FULL_LEVEL) | pop;
  assign ena      = adv_req & space & rst;
  assign push     = ena & up_valid;
  assign dn_valid = (level != '0);
  assign dn_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      rcvd_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= up_data;
        wr_ptr      <= wr_ptr + AW'(1);
        rcvd_cnt    <= rcvd_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (adv_req && !ena) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_drain.sv
// Randomized bench for pipeline_drain: a two-stage pipeline model feeds the DUT and a
// queue-based reference tracks FIFO contents, occupancy and counters.
module tb_pipeline_drain;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic                   clk;
  logic                   rst;
  logic                   adv_req;
  logic [SIZE-1:0]        up_data;
  logic                   up_valid;
  logic                   ena;
  logic [SIZE-1:0]        dn_data;
  logic                   dn_valid;
  logic                   dn_ready;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       rcvd_cnt;
  logic [CNT_W-1:0]       stall_cnt;

  pipeline_drain #(.SIZE(SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .adv_req(adv_req), .up_data(up_data), .up_valid(up_valid),
    .ena(ena), .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .level(level), .rcvd_cnt(rcvd_cnt), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  int unsigned fifo_q[$];
  int unsigned src_q[$];
  int          rcvd_m  = 0;
  int          stall_m = 0;
  bit          pipe_v[2];
  logic [SIZE-1:0] pipe_d[2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SIZE-1:0] nextWord();
    if (src_q.size() > 0) return SIZE'(src_q.pop_front());
    return SIZE'($urandom_range(0, 255));
  endfunction

  task automatic modelReset();
    fifo_q.delete();
    rcvd_m  = 0;
    stall_m = 0;
  endtask

  // One clock cycle: drive at the falling edge, check just after, advance the model at the rising edge.
  task automatic applyStimulus(input bit adv, input bit rdy);
    bit exp_pop, exp_ena, exp_push;
    adv_req  = adv;
    dn_ready = rdy;
    up_valid = pipe_v[1];
    up_data  = pipe_d[1];
    #1;
    exp_pop = rdy && (fifo_q.size() > 0);
    exp_ena = adv && rst && ((fifo_q.size() < DEPTH) || exp_pop);
    checkOutput("ena", ena, exp_ena);
    checkOutput("dn_valid", dn_valid, fifo_q.size() != 0);
    checkOutput("level", level, fifo_q.size());
    if (fifo_q.size() > 0) checkOutput("dn_data", dn_data, fifo_q[0]);
    checkOutput("rcvd_cnt", rcvd_cnt, rcvd_m);
    checkOutput("stall_cnt", stall_cnt, stall_m);
    @(posedge clk);
    if (rst) begin
      exp_push = exp_ena && pipe_v[1];
      if (exp_pop) void'(fifo_q.pop_front());
      if (exp_push) begin
        fifo_q.push_back(pipe_d[1]);
        rcvd_m = (rcvd_m + 1) % CNT_MOD;
      end
      if (adv && !exp_ena) stall_m = (stall_m + 1) % CNT_MOD;
      if (exp_ena) begin
        pipe_v[1] = pipe_v[0];
        pipe_d[1] = pipe_d[0];
        pipe_v[0] = 1'b1;
        pipe_d[0] = nextWord();
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    adv_req = 1'b0;
    dn_ready = 1'b0;
    up_valid = 1'b0;
    up_data = '0;
    pipe_v[0] = 1'b0;
    pipe_v[1] = 1'b0;
    pipe_d[0] = '0;
    pipe_d[1] = '0;
    modelReset();
    @(negedge clk);

    // Held in reset with demand present.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("rst_dn_data", dn_data, 0);

    // Fill and drain three known words through the two-stage pipeline.
    rst = 1'b1;
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("rcvd_three", rcvd_cnt, 3);
    applyStimulus(1'b0, 1'b1);

    // Backpressure until full, then stall.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("full_level", level, DEPTH);

    // Full with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("full_passthru", level, DEPTH);

    // Random traffic; long enough for both counters to wrap.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 2) != 0);
    end

    // Build level 3, then reset asynchronously mid-cycle.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    n = 0;
    while (fifo_q.size() != 3 && n < 30) begin
      applyStimulus(1'b1, 1'b0);
      n++;
    end
    checkOutput("level_three", level, 3);
    adv_req = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("async_level", level, 0);
    checkOutput("async_dn_valid", dn_valid, 0);
    checkOutput("async_ena", ena, 0);
    modelReset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom % 3) != 0, ($urandom % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_drain.md
Name: pipeline_drain

Overview:
- Consumer end of the team's ena-advanced two-stage data pipeline.
- Drives the pipeline's advance enable (`ena`) and captures every valid word the pipeline shifts out into a small FIFO.
- Re-presents the captured words downstream on a valid/ready handshake.
- Guarantees no word leaves the pipeline unless buffer space exists, so the pipeline never loses data under downstream backpressure.

Parameters:
- SIZE, 8, data word width (matches pipeline SIZE).
- DEPTH, 4, FIFO depth in words; power of two, ≥2.
- CNT_W, 16, width of the received-word and stall counters.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-low (rst=0 resets).
- adv_req  input  1  source has a new word on the pipeline input and wants the pipeline advanced.
- up_data  input  SIZE  pipeline output word (pipeline data_out).
- up_valid  input  1  pipeline output valid (pipeline valid).
- ena  output  1  pipeline advance enable (drives pipeline ena); combinational.
- dn_data  output  SIZE  FIFO head word.
- dn_valid  output  1  FIFO non-empty.
- dn_ready  input  1  downstream accepts head word.
- level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- rcvd_cnt  output  CNT_W  count of words captured from the pipeline.
- stall_cnt  output  CNT_W  count of cycles with adv_req=1 and ena=0.

Behaviour:
- Reset (rst=0, async assert, sync-to-clk release):
  - level=0, dn_valid=0, dn_data=0, rcvd_cnt=0, stall_cnt=0.
  - Read/write pointers=0.
  - ena=0 while rst=0.
- pop = dn_valid & dn_ready.
- space = (level < DEPTH) | pop. A simultaneous pop frees a slot in the same cycle.
- ena = adv_req & space & rst; no registered delay.
- push = ena & up_valid.
  - The word on up_data in the ena cycle is the word the pipeline shifts out at that edge; capture it at that same edge.
  - ena with up_valid=0 (pipeline still filling) advances the pipeline but writes nothing.
- FIFO:
  - Circular buffer, pointers wrap modulo DEPTH.
  - dn_data is the head entry (first-word fall-through).
  - dn_valid = (level != 0).
  - Write-to-dn_valid latency is 1 cycle.
- Level update:
  - push only: level+1.
  - pop only: level-1.
  - push & pop: level unchanged, both pointers advance.
  - push & pop at level=DEPTH: legal, no overflow.
  - push & pop at level=0: impossible, since pop requires dn_valid.
- dn_valid=1 with dn_ready=0: dn_data and dn_valid held stable until accepted.
- rcvd_cnt increments on every push; wraps at 2^CNT_W to 0.
- stall_cnt increments each cycle adv_req & !ena; wraps at 2^CNT_W to 0.
- Full and downstream idle (level=DEPTH, dn_ready=0): ena forced 0; the pipeline holds its contents, so no loss.
- Reset mid-operation: FIFO contents discarded; counters cleared; ena drops immediately (async).

Test Plan:
1. Reset with rst=0 for 3 cycles, dn_ready=1, adv_req=1 -> ena=0, dn_valid=0, level=0, counters=0 throughout.
2. Release reset, DEPTH=4, dn_ready=1, adv_req=1; pipeline fed 0x11,0x22,0x33 -> first two ena cycles push nothing (up_valid=0), then dn_data yields 0x11,0x22,0x33 in order with 1-cycle latency; rcvd_cnt=3.
3. dn_ready=0, adv_req=1 continuously -> level climbs to 4, then ena=0; stall_cnt increments each further cycle (10 cycles -> 10); no word dropped when dn_ready later returns 1.
4. level=4, dn_ready=1, adv_req=1 with up_valid=1 -> ena=1 the same cycle, simultaneous push/pop, level stays 4, output order preserved across pointer wrap.
5. Force rcvd_cnt near wrap (CNT_W=4, 17 pushes) -> rcvd_cnt reads 1.
6. Assert rst=0 asynchronously mid-burst with level=3 -> level=0, dn_valid=0, ena=0 before the next clock edge; after release, the next captured word appears first at dn_data.
